multicycle_control: RTL
=======================

# multicycle_control

Main control FSM for the RV32I multi-cycle datapath. Sequences every instruction through fetch, decode, execute, memory and writeback steps. Drives the write enables of the datapath state registers (instruction, old-PC, data, rd1/rd2, ALU result) plus the PC, register-file and memory write strobes and all datapath mux selects. Stalls on a single memory-ready handshake and parks in a trap state on an unsupported opcode.

## Interface
- No parameters; widths are fixed by RV32I.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- opcode  in  7  instr_reg[6:0]
- funct3  in  3  instr_reg[14:12]
- funct7b5  in  1  instr_reg[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC enable
- ir_write  out  1  enable for instr_reg and old_pc_reg
- ab_en  out  1  enable for rd1_reg and rd2_reg
- data_en  out  1  enable for data_reg
- alu_en  out  1  enable for alu_reg
- reg_write  out  1  register-file write
- mem_write  out  1  memory write strobe
- adr_src  out  1  memory address: 0 = PC, 1 = alu_reg
- alu_src_a  out  2  00 = PC, 01 = old_pc, 10 = rd1_reg
- alu_src_b  out  2  00 = rd2_reg, 01 = imm, 10 = constant 4
- result_src  out  2  00 = alu_reg, 01 = data_reg, 10 = ALU output
- imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- halt  out  1  high while in TRAP
- state  out  4  current state (debug)

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BEQ 10, TRAP 11. Any other encoding returns to FETCH next cycle.
- FETCH: adr_src 0, src_a 00, src_b 10, alu_op add, result_src 10. Asserts ir_write and pc_update only when mem_ready = 1. With mem_ready = 1 the next state is DECODE; otherwise it holds in FETCH.
- DECODE: ab_en = 1, alu_en = 1, src_a 01, src_b 01, add (branch target into alu_reg).
  - lw (0000011) or sw (0100011) → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100011 → BEQ
  - anything else → TRAP
- MEMADR: src_a 10, src_b 01, add, alu_en. Next is MEMREAD if opcode[5] = 0, else MEMWRITE.
- MEMREAD: adr_src 1, result_src 00. When mem_ready = 1: data_en = 1 and the next state is MEMWB; otherwise it holds.
- MEMWB: result_src 01, reg_write = 1 → FETCH.
- MEMWRITE: adr_src 1, mem_write = 1 held through the wait. Goes to FETCH on mem_ready = 1.
- EXECR: src_a 10, src_b 00, alu_op funct, alu_en → ALUWB.
- EXECI: src_a 10, src_b 01, alu_op funct, alu_en → ALUWB.
- ALUWB: result_src 00, reg_write = 1 → FETCH.
- JAL: src_a 01, src_b 10, add, alu_en, result_src 00, pc_update = 1 → ALUWB (writes rd = old_pc + 4).
- BEQ: src_a 10, src_b 00, sub, result_src 00, branch = 1 → FETCH.
- TRAP: all write enables are 0 and halt = 1. It is left only by reset.
- pc_write = pc_update | (branch & zero).
- Any strobe not listed for a state is 0. Select signals not listed for a state take their FETCH values.
- imm_src is decoded combinationally from opcode: 0100011 → 01, 1100011 → 10, 1101111 → 11, else 00.
- alu_control:
  - alu_op add → 000; alu_op sub → 001
  - alu_op funct, funct3 000 → 001 if funct7b5 & opcode[5], else 000
  - funct3 010 → 101; 110 → 011; 111 → 010; other funct3 → 000

## Timing
- Reset: rst_n = 0 at a rising edge loads FETCH.
- While rst_n = 0, all outputs are forced combinationally to their reset values: pc_write, ir_write, ab_en, data_en, alu_en, reg_write, mem_write and halt are 0; selects take FETCH values. This holds even mid-instruction, so reset aborts any in-flight access.
- The state register is the only sequential element. All outputs are Moore decodes of state, except pc_write (uses zero), ir_write/data_en/FETCH advance (use mem_ready), and imm_src/alu_control (use instruction fields).
- Cycles per instruction with mem_ready tied high: lw 5, sw 4, R/I-ALU 4, jal 4, beq 3. Each memory wait cycle adds 1.
- mem_ready is sampled only in FETCH, MEMREAD and MEMWRITE and ignored elsewhere.

## Structure
- Shared package riscv_ctrl_pkg holds:
  - state encodings
  - opcode constants
  - alu_op codes (add, sub, funct)
  - alu_control codes
  - select codes for src_a, src_b, result_src and imm_src
- Sub-module alu_decoder (alu_op, funct3, funct7b5, opcode[5] → alu_control) is purely combinational and instantiated once.

## Test plan
- lw with mem_ready = 1 → states 0,1,2,3,4,0. ir_write is asserted only in cycle 1. data_en is asserted in MEMREAD. reg_write with result_src 01 in MEMWB.
- sw with mem_ready low for 2 cycles in MEMWRITE → mem_write = 1 and adr_src = 1 for 3 consecutive cycles, then FETCH. reg_write is never asserted.
- beq:
  - zero = 1 in BEQ → pc_write = 1, alu_control = 001, 3-cycle instruction.
  - zero = 0 → pc_write = 0.
- R-type sub (opcode 0110011, funct3 000, funct7b5 1) → alu_control 001 in EXECR. I-type addi with funct7b5 = 1 → 000.
- Opcode 0000000 → TRAP in the cycle after DECODE. halt = 1, all enables 0 for 10 cycles. rst_n low for one edge → FETCH, halt = 0.
- rst_n low during MEMWRITE with mem_ready = 0 → mem_write drops in the same cycle, and state = FETCH after that edge.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// riscv_ctrl_pkg
// Shared definitions for the RV32I multi-cycle control path: FSM state
// encodings, opcode constants, ALU operation classes, ALU control codes and
// the datapath mux select codes. Also provides the immediate-format decode
// used by the controller.
// ----------------------------------------------------------------------------
package riscv_ctrl_pkg;

    // FSM states; the numeric values are visible on the debug state port.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    // Supported opcodes
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    // Operation class requested by the FSM from the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    // ALU control codes driven to the datapath ALU
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result bus select
    localparam logic [1:0] RES_ALUREG = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALUOUT = 2'b10;

    // Immediate format select
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format follows the opcode alone; everything not S/B/J is I.
    function automatic logic [1:0] imm_src_of(input logic [6:0] opcode);
        case (opcode)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ----------------------------------------------------------------------------
// alu_decoder
// Purely combinational translation of the FSM's ALU operation class plus the
// instruction function fields into the ALU control code.
// Ports:
//   alu_op      in  2  operation class from the FSM (add / sub / funct)
//   funct3      in  3  instr[14:12]
//   funct7b5    in  1  instr[30]
//   op5         in  1  opcode[5] (distinguishes R-type from I-type)
//   alu_control out 3  ALU control code
// ----------------------------------------------------------------------------
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    // funct7b5 only means "subtract" for R-type; in I-type it is immediate bits.
    logic w_is_sub;
    assign w_is_sub = funct7b5 & op5;

    always_comb begin
        // NOTE: default first so every path assigns the output; no latch.
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = w_is_sub ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
// Main control FSM of the RV32I multi-cycle datapath. Sequences each
// instruction through fetch / decode / execute / memory / writeback, drives
// the datapath register enables, write strobes and mux selects, stalls on
// mem_ready, and parks in TRAP on an unsupported opcode until reset.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   opcode/funct3/funct7b5  instruction register fields
//   zero           ALU zero flag (branch decision)
//   mem_ready      memory completes the current access this cycle
//   pc_write, ir_write, ab_en, data_en, alu_en   register enables
//   reg_write, mem_write                         write strobes
//   adr_src, alu_src_a, alu_src_b, result_src, imm_src, alu_control  selects
//   halt           high while trapped
//   state          current FSM state (debug)
// ----------------------------------------------------------------------------
module multicycle_control
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       ab_en,
    output logic       data_en,
    output logic       alu_en,
    output logic       reg_write,
    output logic       mem_write,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       halt,
    output logic [3:0] state
);

    state_t  r_state;
    state_t  w_next_state;
    alu_op_t w_alu_op;
    logic    w_pc_update;
    logic    w_branch;

    // ------------------------------------------------------------------
    // State register: the only sequential element
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop samples pre-edge values.
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next_state;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:    w_next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_EXECR;
                    OP_ITYPE:     w_next_state = S_EXECI;
                    OP_JAL:       w_next_state = S_JAL;
                    OP_BEQ:       w_next_state = S_BEQ;
                    default:      w_next_state = S_TRAP;
                endcase
            end
            // opcode[5] is the only bit separating lw from sw.
            S_MEMADR:   w_next_state = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next_state = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: w_next_state = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    w_next_state = S_ALUWB;
            S_EXECI:    w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_JAL:      w_next_state = S_ALUWB;
            S_BEQ:      w_next_state = S_FETCH;
            S_TRAP:     w_next_state = S_TRAP;
            default:    w_next_state = S_FETCH;  // unused encodings recover
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode. Defaults are the FETCH selects with every strobe low;
    // while rst_n is low the case is skipped so the defaults are forced,
    // which aborts any in-flight access in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        ir_write    = 1'b0;
        ab_en       = 1'b0;
        data_en     = 1'b0;
        alu_en      = 1'b0;
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        halt        = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_FOUR;
        result_src  = RES_ALUOUT;
        w_alu_op    = ALUOP_ADD;

        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    // PC+4 goes straight back to the PC via the ALU output.
                    ir_write    = mem_ready;
                    w_pc_update = mem_ready;
                end
                S_DECODE: begin
                    // Precompute the branch target (old_pc + imm) into alu_reg.
                    ab_en     = 1'b1;
                    alu_en    = 1'b1;
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                end
                S_MEMADR: begin
                    alu_en    = 1'b1;
                    alu_src_a = SRCA_RD1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEMREAD: begin
                    adr_src    = 1'b1;
                    result_src = RES_ALUREG;
                    data_en    = mem_ready;
                end
                S_MEMWB: begin
                    result_src = RES_DATA;
                    reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    adr_src   = 1'b1;
                    mem_write = 1'b1;
                end
                S_EXECR: begin
                    alu_en    = 1'b1;
                    alu_src_a = SRCA_RD1;
                    alu_src_b = SRCB_RD2;
                    w_alu_op  = ALUOP_FUNCT;
                end
                S_EXECI: begin
                    alu_en    = 1'b1;
                    alu_src_a = SRCA_RD1;
                    alu_src_b = SRCB_IMM;
                    w_alu_op  = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    result_src = RES_ALUREG;
                    reg_write  = 1'b1;
                end
                S_JAL: begin
                    // PC takes the target from alu_reg while the ALU forms
                    // old_pc + 4 as the link value for the ALUWB step.
                    alu_en      = 1'b1;
                    alu_src_a   = SRCA_OLDPC;
                    alu_src_b   = SRCB_FOUR;
                    result_src  = RES_ALUREG;
                    w_pc_update = 1'b1;
                end
                S_BEQ: begin
                    alu_src_a  = SRCA_RD1;
                    alu_src_b  = SRCB_RD2;
                    result_src = RES_ALUREG;
                    w_alu_op   = ALUOP_SUB;
                    w_branch   = 1'b1;
                end
                S_TRAP: begin
                    halt = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign pc_write = w_pc_update | (w_branch & zero);
    assign imm_src  = imm_src_of(opcode);
    assign state    = r_state;

    alu_decoder u_alu_decoder (
        .alu_op      (w_alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (opcode[5]),
        .alu_control (alu_control)
    );

endmodule
